// File: rtl/e_mdu.sv
// e_mdu -- execute-stage multiply/divide unit.
//
// Owns the architectural HI/LO registers, models the multi-cycle latency of
// mult/multu/div/divu (and optionally madd), raises Busy toward the D-stage
// hazard unit while an operation is in flight, and supplies mfhi/mflo data.
//
// Optional feature: define MDU_MADD_EN to enable MDOp=100 (madd,
// {HI,LO} += signed(A)*signed(B)). Without it MDOp=100 is reserved.
//
// Ports:
//   clk      in   1  clock, rising edge
//   reset    in   1  asynchronous, active-high reset
//   Req      in   1  exception/interrupt request; suppresses Start/HIWrite/LOWrite
//   Start    in   1  E-stage instruction is a mult/div class op
//   MDOp     in   3  000 mult, 001 multu, 010 div, 011 divu, 100 madd, others reserved
//   HIWrite  in   1  mthi in E
//   LOWrite  in   1  mtlo in E
//   HIRead   in   1  mfhi in E
//   LORead   in   1  mflo in E
//   A        in  32  forwarded rs operand
//   B        in  32  forwarded rt operand
//   Busy     out  1  operation in flight
//   HI       out 32  architectural HI
//   LO       out 32  architectural LO
//   MDOut    out 32  HIRead ? HI : (LORead ? LO : 0)
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic        HIWrite,
  input  logic        LOWrite,
  input  logic        HIRead,
  input  logic        LORead,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        r_pend_we;

  logic        w_legal;
  logic        w_is_div;
  logic        w_div_signed;
  logic        w_idle;
  logic        w_start;
  logic        w_mtx_ok;
  logic        w_done;
  logic [3:0]  w_lat;

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_dvd;
  logic [31:0] w_dvs;
  logic [31:0] w_dvs_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_res_we;
`ifdef MDU_MADD_EN
  logic [63:0] w_madd;
`endif

  // Opcode decode
  always_comb begin
    w_legal = 1'b0;
    case (MDOp)
      3'b000, 3'b001, 3'b010, 3'b011: w_legal = 1'b1;
`ifdef MDU_MADD_EN
      3'b100:                         w_legal = 1'b1;
`endif
      default:                        w_legal = 1'b0;
    endcase
  end

  assign w_is_div     = (MDOp == 3'b010) || (MDOp == 3'b011);
  assign w_div_signed = (MDOp == 3'b010);
  assign w_idle       = (r_state == S_IDLE);
  assign w_start      = w_idle && Start && !Req && w_legal;
  assign w_mtx_ok     = w_idle && !Req;
  assign w_done       = (r_state == S_BUSY) && (r_cnt == 4'd1);
  assign w_lat        = w_is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

  // Multipliers: low 64 bits of sign-/zero-extended 64x64 products
  assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // One shared unsigned divider on magnitudes; signs are restored afterwards.
  // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 / 1, same signs.
  assign w_dvd      = (w_div_signed && A[31]) ? (~A + 32'd1) : A;
  assign w_dvs      = (w_div_signed && B[31]) ? (~B + 32'd1) : B;
  assign w_dvs_safe = (B == '0) ? 32'd1 : w_dvs;
  assign w_q_mag    = w_dvd / w_dvs_safe;
  assign w_r_mag    = w_dvd % w_dvs_safe;
  assign w_q        = (w_div_signed && (A[31] ^ B[31])) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_r        = (w_div_signed && A[31]) ? (32'd0 - w_r_mag) : w_r_mag;

`ifdef MDU_MADD_EN
  assign w_madd = {r_hi, r_lo} + w_prod_s;
`endif

  // Result captured at the Start edge; a zero divisor suppresses the commit
  always_comb begin
    w_res_hi = w_prod_s[63:32];
    w_res_lo = w_prod_s[31:0];
    w_res_we = 1'b1;
    case (MDOp)
      3'b001: begin
        w_res_hi = w_prod_u[63:32];
        w_res_lo = w_prod_u[31:0];
      end
      3'b010, 3'b011: begin
        w_res_hi = w_r;
        w_res_lo = w_q;
        w_res_we = (B != '0);
      end
`ifdef MDU_MADD_EN
      3'b100: begin
        w_res_hi = w_madd[63:32];
        w_res_lo = w_madd[31:0];
      end
`endif
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_done)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counter, pending result and HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_we <= 1'b0;
    end else begin
      if (w_start) begin
        r_cnt     <= w_lat;
        r_pend_hi <= w_res_hi;
        r_pend_lo <= w_res_lo;
        r_pend_we <= w_res_we;
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt - 4'd1;
        if (w_done && r_pend_we) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
      end
      if (w_mtx_ok && HIWrite) r_hi <= A;
      if (w_mtx_ok && LOWrite) r_lo <= A;
    end
  end

  assign Busy  = (r_state == S_BUSY);
  assign HI    = r_hi;
  assign LO    = r_lo;
  assign MDOut = HIRead ? r_hi : (LORead ? r_lo : '0);

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu -- self-checking bench for e_mdu. HI/LO expectations come from a
// plain-arithmetic model (longint products, int division) of the mult/div
// rules; latency expectations come from the configured cycle counts.
module tb_e_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  typedef longint unsigned u64_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req;
  logic        Start;
  logic [2:0]  MDOp;
  logic        HIWrite;
  logic        LOWrite;
  logic        HIRead;
  logic        LORead;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDOut;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Req(Req), .Start(Start), .MDOp(MDOp),
    .HIWrite(HIWrite), .LOWrite(LOWrite), .HIRead(HIRead), .LORead(LORead),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO), .MDOut(MDOut)
  );

  always #5 clk = ~clk;

  // Reference model: updates m_hi/m_lo, returns expected Busy cycles
  function automatic int ref_op(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic req);
    int     lat;
    int     sa;
    int     sb;
    longint p;
    u64_t   pu;
    lat = 0;
    sa  = a;
    sb  = b;
    if (!req) begin
      case (op)
        3'b000: begin
          p = longint'(sa) * longint'(sb);
          {m_hi, m_lo} = p;
          lat = MC;
        end
        3'b001: begin
          pu = u64_t'(a) * u64_t'(b);
          {m_hi, m_lo} = pu;
          lat = MC;
        end
        3'b010: begin
          if (b != 0) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
              m_lo = 32'h8000_0000;
              m_hi = 32'h0;
            end else begin
              m_lo = sa / sb;
              m_hi = sa % sb;
            end
          end
          lat = DC;
        end
        3'b011: begin
          if (b != 0) begin
            m_lo = a / b;
            m_hi = a % b;
          end
          lat = DC;
        end
        3'b100: begin
`ifdef MDU_MADD_EN
          p = longint'(sa) * longint'(sb);
          pu = u64_t'({m_hi, m_lo}) + u64_t'(p);
          {m_hi, m_lo} = pu;
          lat = MC;
`else
          lat = 0;
`endif
        end
        default: lat = 0;
      endcase
    end
    return lat;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = $urandom_range(0, 15);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issue one Start cycle and count Busy cycles (bounded); -1 means timeout
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic req, output int lat);
    @(negedge clk);
    Start = 1'b1; MDOp = op; A = a; B = b; Req = req;
    @(negedge clk);
    Start = 1'b0; Req = 1'b0;
    lat = 0;
    while (Busy === 1'b1 && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    if (lat >= 40) lat = -1;
  endtask

  task automatic wr(input logic hw, input logic lw, input logic [31:0] a, input logic req);
    @(negedge clk);
    HIWrite = hw; LOWrite = lw; A = a; Req = req;
    @(negedge clk);
    HIWrite = 1'b0; LOWrite = 1'b0; Req = 1'b0;
    if (!req && hw) m_hi = a;
    if (!req && lw) m_lo = a;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    HIRead = 1'b1;
    #1;
    n_checks++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", Busy); end
    n_checks++; if (HI !== 32'h0) begin n_err++; $display("FAIL reset_hi got %h exp 0", HI); end
    n_checks++; if (LO !== 32'h0) begin n_err++; $display("FAIL reset_lo got %h exp 0", LO); end
    n_checks++; if (MDOut !== 32'h0) begin n_err++; $display("FAIL reset_mdout got %h exp 0", MDOut); end
    HIRead = 1'b0;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mult();
    int lat;
    int exp_lat;
    exp_lat = ref_op(3'b000, 32'hFFFF_FFFD, 32'd5, 1'b0);
    run_op(3'b000, 32'hFFFF_FFFD, 32'd5, 1'b0, lat);
    n_checks++; if (lat !== exp_lat) begin n_err++; $display("FAIL mult_lat got %0d exp %0d", lat, exp_lat); end
    n_checks++; if (HI !== m_hi) begin n_err++; $display("FAIL mult_hi got %h exp %h", HI, m_hi); end
    n_checks++; if (LO !== m_lo) begin n_err++; $display("FAIL mult_lo got %h exp %h", LO, m_lo); end
    LORead = 1'b1; #1;
    n_checks++; if (MDOut !== 32'hFFFF_FFF1) begin n_err++; $display("FAIL mult_mflo got %h exp fffffff1", MDOut); end
    LORead = 1'b0;
    exp_lat = ref_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    n_checks++; if (lat !== exp_lat) begin n_err++; $display("FAIL multu_lat got %0d exp %0d", lat, exp_lat); end
    n_checks++; if ({HI, LO} !== {m_hi, m_lo}) begin n_err++; $display("FAIL multu_hilo got %h%h exp %h%h", HI, LO, m_hi, m_lo); end
  endtask

  task automatic test_div();
    int lat;
    int exp_lat;
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    logic [2:0]  top [3];
    ta[0] = 32'd7;         tb[0] = 32'd2;         top[0] = 3'b011;
    ta[1] = 32'hFFFF_FFF9; tb[1] = 32'd2;         top[1] = 3'b010;
    ta[2] = 32'h8000_0000; tb[2] = 32'hFFFF_FFFF; top[2] = 3'b010;
    for (int i = 0; i < 3; i++) begin
      exp_lat = ref_op(top[i], ta[i], tb[i], 1'b0);
      run_op(top[i], ta[i], tb[i], 1'b0, lat);
      n_checks++; if (lat !== exp_lat) begin n_err++; $display("FAIL div%0d_lat got %0d exp %0d", i, lat, exp_lat); end
      n_checks++; if (HI !== m_hi) begin n_err++; $display("FAIL div%0d_hi got %h exp %h", i, HI, m_hi); end
      n_checks++; if (LO !== m_lo) begin n_err++; $display("FAIL div%0d_lo got %h exp %h", i, LO, m_lo); end
    end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    HIWrite = 1'b1; A = 32'h1234_5678;
    @(negedge clk);
    n_checks++; if (HI !== 32'h1234_5678) begin n_err++; $display("FAIL mthi_hi got %h exp 12345678", HI); end
    n_checks++; if (LO !== m_lo) begin n_err++; $display("FAIL mthi_lo got %h exp %h", LO, m_lo); end
    n_checks++; if (Busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy got %b exp 0", Busy); end
    HIWrite = 1'b0; LOWrite = 1'b1; A = 32'h9ABC_DEF0;
    @(negedge clk);
    LOWrite = 1'b0;
    m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;
    n_checks++; if (LO !== m_lo) begin n_err++; $display("FAIL mtlo_lo got %h exp %h", LO, m_lo); end
    n_checks++; if (Busy !== 1'b0) begin n_err++; $display("FAIL mtlo_busy got %b exp 0", Busy); end
    HIRead = 1'b1; LORead = 1'b1; #1;
    n_checks++; if (MDOut !== 32'h1234_5678) begin n_err++; $display("FAIL mfhi_prio got %h exp 12345678", MDOut); end
    HIRead = 1'b0; #1;
    n_checks++; if (MDOut !== 32'h9ABC_DEF0) begin n_err++; $display("FAIL mflo got %h exp 9abcdef0", MDOut); end
    LORead = 1'b0; #1;
    n_checks++; if (MDOut !== 32'h0) begin n_err++; $display("FAIL mdout_idle got %h exp 0", MDOut); end
  endtask

  task automatic test_req();
    int lat;
    int exp_lat;
    exp_lat = ref_op(3'b000, 32'd9, 32'd9, 1'b1);
    run_op(3'b000, 32'd9, 32'd9, 1'b1, lat);
    n_checks++; if (lat !== exp_lat) begin n_err++; $display("FAIL req_start_lat got %0d exp %0d", lat, exp_lat); end
    n_checks++; if ({HI, LO} !== {m_hi, m_lo}) begin n_err++; $display("FAIL req_start_hilo got %h%h exp %h%h", HI, LO, m_hi, m_lo); end
    wr(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
    n_checks++; if ({HI, LO} !== {m_hi, m_lo}) begin n_err++; $display("FAIL req_mtx_hilo got %h%h exp %h%h", HI, LO, m_hi, m_lo); end
    // Req raised during the second Busy cycle must not abort the multiply
    exp_lat = ref_op(3'b000, 32'h0001_0003, 32'hFFFF_0007, 1'b0);
    @(negedge clk);
    Start = 1'b1; MDOp = 3'b000; A = 32'h0001_0003; B = 32'hFFFF_0007;
    @(negedge clk);
    Start = 1'b0;
    lat = 0;
    while (Busy === 1'b1 && lat < 40) begin
      lat++;
      Req = (lat == 2);
      @(negedge clk);
    end
    Req = 1'b0;
    n_checks++; if (lat !== exp_lat) begin n_err++; $display("FAIL req_busy_lat got %0d exp %0d", lat, exp_lat); end
    n_checks++; if ({HI, LO} !== {m_hi, m_lo}) begin n_err++; $display("FAIL req_busy_hilo got %h%h exp %h%h", HI, LO, m_hi, m_lo); end
  endtask

  task automatic test_divzero();
    int lat;
    int exp_lat;
    wr(1'b1, 1'b0, 32'h11, 1'b0);
    wr(1'b0, 1'b1, 32'h22, 1'b0);
    for (int i = 0; i < 2; i++) begin
      exp_lat = ref_op(i == 0 ? 3'b010 : 3'b011, 32'h55, 32'h0, 1'b0);
      run_op(i == 0 ? 3'b010 : 3'b011, 32'h55, 32'h0, 1'b0, lat);
      n_checks++; if (lat !== exp_lat) begin n_err++; $display("FAIL divz%0d_lat got %0d exp %0d", i, lat, exp_lat); end
      n_checks++; if ({HI, LO} !== {32'h11, 32'h22}) begin n_err++; $display("FAIL divz%0d_hilo got %h%h exp 0000001100000022", i, HI, LO); end
    end
  endtask

  task automatic test_ignored();
    int lat;
    int exp_lat;
    exp_lat = ref_op(3'b001, 32'd1000, 32'd3000, 1'b0);
    @(negedge clk);
    Start = 1'b1; MDOp = 3'b001; A = 32'd1000; B = 32'd3000;
    @(negedge clk);
    lat = 0;
    // Hammer Start/mthi/mtlo while busy; all of it must be dropped
    while (Busy === 1'b1 && lat < 40) begin
      lat++;
      Start = 1'b1; MDOp = 3'b011; HIWrite = 1'b1; LOWrite = 1'b1;
      A = $urandom; B = 32'd3;
      @(negedge clk);
    end
    Start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0;
    n_checks++; if (lat !== exp_lat) begin n_err++; $display("FAIL busy_ign_lat got %0d exp %0d", lat, exp_lat); end
    n_checks++; if ({HI, LO} !== {m_hi, m_lo}) begin n_err++; $display("FAIL busy_ign_hilo got %h%h exp %h%h", HI, LO, m_hi, m_lo); end
    for (int op = 4; op < 8; op++) begin
      exp_lat = ref_op(3'(op), 32'd6, 32'd7, 1'b0);
      run_op(3'(op), 32'd6, 32'd7, 1'b0, lat);
      n_checks++; if (lat !== exp_lat) begin n_err++; $display("FAIL op%0d_lat got %0d exp %0d", op, lat, exp_lat); end
      n_checks++; if ({HI, LO} !== {m_hi, m_lo}) begin n_err++; $display("FAIL op%0d_hilo got %h%h exp %h%h", op, HI, LO, m_hi, m_lo); end
    end
  endtask

  task automatic test_reset_mid();
    wr(1'b1, 1'b1, 32'hA5A5_0001, 1'b0);
    @(negedge clk);
    Start = 1'b1; MDOp = 3'b011; A = 32'd100; B = 32'd7;
    @(negedge clk);
    Start = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    m_hi = '0; m_lo = '0;
    n_checks++; if (Busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b exp 0", Busy); end
    n_checks++; if ({HI, LO} !== 64'h0) begin n_err++; $display("FAIL rstmid_hilo got %h%h exp 0", HI, LO); end
    @(negedge clk);
    reset = 1'b0;
    repeat (DC + 2) @(negedge clk);
    n_checks++; if (Busy !== 1'b0) begin n_err++; $display("FAIL rstmid_after_busy got %b exp 0", Busy); end
    n_checks++; if ({HI, LO} !== 64'h0) begin n_err++; $display("FAIL rstmid_after_hilo got %h%h exp 0", HI, LO); end
  endtask

`ifdef MDU_MADD_EN
  task automatic test_madd();
    int lat;
    int exp_lat;
    wr(1'b1, 1'b1, 32'h0, 1'b0);
    wr(1'b0, 1'b1, 32'h1, 1'b0);
    exp_lat = ref_op(3'b100, 32'd2, 32'd3, 1'b0);
    run_op(3'b100, 32'd2, 32'd3, 1'b0, lat);
    n_checks++; if (lat !== exp_lat) begin n_err++; $display("FAIL madd_lat got %0d exp %0d", lat, exp_lat); end
    n_checks++; if ({HI, LO} !== {32'h0, 32'h7}) begin n_err++; $display("FAIL madd_hilo got %h%h exp 0000000000000007", HI, LO); end
  endtask
`endif

  task automatic test_random();
    int lat;
    int exp_lat;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        req;
    logic        hr;
    logic        lr;
    logic [31:0] exp_md;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        wr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0));
      end else begin
        op  = 3'($urandom_range(0, 7));
        a   = pick();
        b   = pick();
        req = ($urandom_range(0, 7) == 0);
        exp_lat = ref_op(op, a, b, req);
        run_op(op, a, b, req, lat);
        n_checks++; if (lat !== exp_lat) begin n_err++; $display("FAIL rnd%0d_lat op %0d got %0d exp %0d", i, op, lat, exp_lat); end
      end
      n_checks++; if ({HI, LO} !== {m_hi, m_lo}) begin n_err++; $display("FAIL rnd%0d_hilo got %h%h exp %h%h", i, HI, LO, m_hi, m_lo); end
      hr = 1'($urandom_range(0, 1));
      lr = 1'($urandom_range(0, 1));
      HIRead = hr; LORead = lr;
      #1;
      exp_md = hr ? m_hi : (lr ? m_lo : 32'h0);
      n_checks++; if (MDOut !== exp_md) begin n_err++; $display("FAIL rnd%0d_mdout got %h exp %h", i, MDOut, exp_md); end
      HIRead = 1'b0; LORead = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; Req = 1'b0; Start = 1'b0; MDOp = 3'b000;
    HIWrite = 1'b0; LOWrite = 1'b0; HIRead = 1'b0; LORead = 1'b0;
    A = '0; B = '0; m_hi = '0; m_lo = '0;
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_req();
    test_divzero();
    test_ignored();
`ifdef MDU_MADD_EN
    test_madd();
`endif
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
